sd_1011_fsm: RTL and testbench
==============================

# sd_1011_fsm

Serial bit-stream sequence detector for the pattern 1-0-1-1, implemented as a non-overlapping Mealy state machine. It samples one input bit per clock and asserts a single-cycle detect flag combinationally during the cycle in which the final `1` of the pattern is presented. It is used as a standalone protocol/marker detector on a one-bit serial data line.

## Interface
- No parameters. Pattern 1011 and MSB-first arrival order are fixed.
- Port order for positional instantiation: clk, rst, signal, out.
- `clk`  input  1  Single clock; all state updates on rising edge.
- `rst`  input  1  Reset; synchronous, active-high. Sampled on the `clk` rising edge.
- `signal`  input  1  Serial data bit; one bit consumed per rising edge of `clk`.
- `out`  output  1  Detect flag; Mealy output, high while the final `1` of 1011 is on `signal`.

## Operation
- 2-bit state register, four states:
  - S0: idle, no useful prefix.
  - S1: seen `1`.
  - S10: seen `10`.
  - S101: seen `101`.
- Transitions (`signal` = 0 / 1):
  - S0 -> S0 / S1
  - S1 -> S10 / S1
  - S10 -> S0 / S101
  - S101 -> S10 / S0, with `out` = 1 on the `1` branch.
- Non-overlapping: after a detection the FSM returns to S0. No bits of the detected pattern are reused for the next match.
- On a `0` from S101, the suffix `10` is retained, so the FSM goes to S10.
- `out` = (state == S101) AND `signal` AND NOT `rst`. It is purely combinational from the current state and the current input; there is no output register.
- While `rst` = 1: state is loaded with S0 on every rising edge, and `out` is forced to 0.
- An X or Z on `signal` is not a supported input. No recovery behaviour is required beyond the next reset.

## Timing
- Bit k is sampled at rising edge k.
- `out` is valid during the cycle in which the 4th pattern bit is driven, before that edge: zero-cycle Mealy latency.
- `out` pulse width is at most one clock cycle per detection, assuming `signal` changes once per cycle.
- Back-to-back detections need at least 4 new bits after the previous match (non-overlapping).
- Reset:
  - Synchronous. The state is S0 after the first rising edge with `rst` = 1.
  - `out` = 0 immediately while `rst` is high.
  - Reset asserted mid-pattern discards the partial match.
  - First bit counted is the one sampled on the first edge after `rst` deasserts.
- No handshakes; input is assumed valid every cycle.

## Test plan
- Reset: hold `rst` = 1 for 2 edges with `signal` = 1 -> `out` = 0 throughout; state = S0 after release.
- Basic detect: after reset, drive 1,0,1,1 -> `out` = 0,0,0,1; `out` is high only while the 4th bit is driven, and the FSM returns to S0.
- Non-overlap: drive 1,0,1,1,0,1,1 -> exactly one pulse, on bit 4. Bit 7 does not fire, because the trailing `1` of the first match is not reused.
- Back-to-back: drive 1,0,1,1,1,0,1,1 -> pulses on bits 4 and 8.
- Prefix retention: drive 1,0,1,0,1,1 -> single pulse on bit 6 (S101 -0-> S10 path). Drive 1,1,0,1,1 -> pulse on bit 5 (S1 self-loop).
- Mid-pattern reset: drive 1,0,1, then assert `rst` for 1 cycle, then drive 1 -> no pulse. Then drive 0,1,1 -> pulse on the last bit.

Source files
------------

// File: rtl/sd_1011_fsm.sv
// sd_1011_fsm
//   Serial detector for the bit pattern 1-0-1-1 (first bit first). It is a
//   non-overlapping Mealy machine: the detect flag is driven combinationally
//   while the final 1 of the pattern is on the input, and the machine then
//   restarts from idle, so no bits of a detected pattern are reused.
//
// Ports
//   clk     in   single clock, all state updates on the rising edge
//   rst     in   synchronous active-high reset
//   signal  in   serial data bit, one bit consumed per rising edge
//   out     out  detect flag, high while the final 1 of 1011 is on signal
module sd_1011_fsm (
  input  logic clk,
  input  logic rst,
  input  logic signal,
  output logic out
);

  localparam logic [1:0] S0   = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S10  = 2'd2;
  localparam logic [1:0] S101 = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;

  // State register; reset forces the idle state on every rising edge while
  // rst is held, which discards any partially matched prefix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. From S101 a 0 keeps the "10" suffix (go to S10),
  // while a 1 completes the match and returns to idle so the matched bits
  // cannot seed the next detection.
  always_comb begin
    state_next = state;
    case (state)
      S0:      state_next = signal ? S1   : S0;
      S1:      state_next = signal ? S1   : S10;
      S10:     state_next = signal ? S101 : S0;
      S101:    state_next = signal ? S0   : S10;
      default: state_next = S0;
    endcase
  end

  // Mealy output: no register, so the flag appears in the same cycle the
  // final bit is presented. Reset masks it immediately.
  assign out = (state == S101) && signal && !rst;

endmodule

// File: tb/tb_sd_1011_fsm.sv
// tb_sd_1011_fsm
//   Directed bench for sd_1011_fsm. Each step drives one input bit (and the
//   reset level), pushes the expected detect flag onto a scoreboard queue,
//   and pops/compares it against the DUT output mid-cycle, before the
//   rising edge that consumes the bit.
module tb_sd_1011_fsm;

  logic clk;
  logic rst;
  logic signal;
  logic out;

  int errors;
  int checks;
  logic exp_q[$];

  sd_1011_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .signal (signal),
    .out    (out)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pops the oldest expected flag and compares it with the DUT output.
  task automatic checkOutput(input string tag);
    logic expected;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: observed=queue-empty expected=entry", tag);
    end else begin
      expected = exp_q.pop_front();
      checks++;
      assert (out === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%b expected=%b", tag, out, expected);
      end
    end
  endtask

  // Drives one bit after the falling edge, records the expected flag, then
  // checks it well before the next rising edge consumes the bit.
  task automatic applyStimulus(input logic bit_v, input logic rst_v,
                               input logic exp_out, input string tag);
    @(negedge clk);
    signal = bit_v;
    rst    = rst_v;
    exp_q.push_back(exp_out);
    #2;
    checkOutput(tag);
  endtask

  // Plays a whole pattern with reset low; exp holds the expected flag per bit.
  task automatic playSeq(input logic [15:0] bits, input logic [15:0] exp,
                         input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) begin
      applyStimulus(bits[i], 1'b0, exp[i], $sformatf("%s_b%0d", tag, len - i));
    end
  endtask

  // One reset cycle with signal low to start the next scenario from idle.
  task automatic doReset(input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    signal = 1'b1;

    $display("[TB] reset hold with signal high");
    applyStimulus(1'b1, 1'b1, 1'b0, "reset_edge1");
    applyStimulus(1'b1, 1'b1, 1'b0, "reset_edge2");

    $display("[TB] basic detect 1011");
    playSeq(16'b1011, 16'b0001, 4, "basic");

    $display("[TB] idle after detect: 011 must not fire");
    playSeq(16'b011, 16'b000, 3, "after_basic");

    doReset("rst_a");
    $display("[TB] non-overlap 1011011");
    playSeq(16'b1011011, 16'b0001000, 7, "nonoverlap");

    doReset("rst_b");
    $display("[TB] back-to-back 10111011");
    playSeq(16'b10111011, 16'b00010001, 8, "b2b");

    doReset("rst_c");
    $display("[TB] prefix retention 101011");
    playSeq(16'b101011, 16'b000001, 6, "retain10");

    doReset("rst_d");
    $display("[TB] self-loop 11011");
    playSeq(16'b11011, 16'b00001, 5, "selfloop");

    doReset("rst_e");
    $display("[TB] mid-pattern reset");
    playSeq(16'b101, 16'b000, 3, "mid_pre");
    applyStimulus(1'b1, 1'b1, 1'b0, "mid_rst_masks");
    applyStimulus(1'b1, 1'b0, 1'b0, "mid_after_1");
    playSeq(16'b011, 16'b001, 3, "mid_tail");

    $display("[TB] reset masks output while in S101");
    doReset("rst_f");
    playSeq(16'b101, 16'b000, 3, "mask_pre");
    applyStimulus(1'b1, 1'b1, 1'b0, "mask_rst");
    applyStimulus(1'b1, 1'b0, 1'b0, "mask_after");

    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
